// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order responses
// into a prefetch FIFO, and redirect handling with stale-response discard.
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DISC_W = CNT_W + 4;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   fifo_data_q [DEPTH];
  logic [XLEN-1:0]   fifo_data_d [DEPTH];
  logic [XLEN-1:0]   fifo_pc_q   [DEPTH];
  logic [XLEN-1:0]   fifo_pc_d   [DEPTH];
  logic [XLEN-1:0]   iq_pc_q     [DEPTH];
  logic [XLEN-1:0]   iq_pc_d     [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [DISC_W-1:0] discard_q, discard_d;

  logic [CNT_W:0] credit_used;
  logic           req_fire, rsp_drop, rsp_live, pop;

  // Every live outstanding request is guaranteed a FIFO slot by this credit check.
  assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = rst_n & ~redirect_valid & (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = pc_q;

  assign instr_valid = rst_n & (count_q != '0);
  assign instruction = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_drop = imem_rsp_valid & (discard_q != '0);
  assign rsp_live = imem_rsp_valid & (discard_q == '0) & (outstanding_q != '0);
  assign pop      = instr_valid & instr_ready;

  always_comb begin
    pc_d          = pc_q;
    fifo_data_d   = fifo_data_q;
    fifo_pc_d     = fifo_pc_q;
    iq_pc_d       = iq_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    iq_rd_d       = iq_rd_q;
    iq_wr_d       = iq_wr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (redirect_valid) begin
      // A response landing this cycle is one of the in-flight ones, so it nets out.
      pc_d          = redirect_pc;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      iq_rd_d       = '0;
      iq_wr_d       = '0;
      count_d       = '0;
      outstanding_d = '0;
      discard_d     = discard_q + DISC_W'(outstanding_q) - DISC_W'(rsp_drop | rsp_live);
    end else begin
      if (req_fire) begin
        pc_d             = pc_q + XLEN'(4);
        iq_pc_d[iq_wr_q] = pc_q;
        iq_wr_d          = iq_wr_q + PTR_W'(1);
      end
      if (rsp_drop) begin
        discard_d = discard_q - DISC_W'(1);
      end
      if (rsp_live) begin
        fifo_data_d[wr_ptr_q] = imem_rsp_data;
        fifo_pc_d[wr_ptr_q]   = iq_pc_q[iq_rd_q];
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        iq_rd_d               = iq_rd_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
      count_d       = count_q + CNT_W'(rsp_live) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      fifo_data_q   <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
      iq_pc_q       <= '{default: '0};
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      iq_rd_q       <= '0;
      iq_wr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      fifo_data_q   <= fifo_data_d;
      fifo_pc_q     <= fifo_pc_d;
      iq_pc_q       <= iq_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      iq_rd_q       <= iq_rd_d;
      iq_wr_q       <= iq_wr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for reset/stream/backpressure, hand sequences
// for redirect corner cases, then random traffic against a PC-stream model.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  // Memory model: in-order responses, word at address a is a + 0x100.
  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  mem_req_t mem_q[$];
  int last_due = -1;
  int lat_min = 1;
  int lat_max = 1;

  // Reference model: the decoder must see a sequential PC stream from the last reset/redirect.
  logic [31:0] model_fetch_pc = RESET_PC;
  logic [31:0] model_dec_pc = RESET_PC;
  logic [31:0] popped_q[$];
  int          pops = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_ins = '0;

  typedef struct {
    logic        rst;
    logic        rq_rdy;
    logic        i_rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
  } vec_t;
  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic rq_rdy, input logic i_rdy,
                               input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    rst_n          = rst_v;
    imem_req_ready = rq_rdy;
    instr_ready    = i_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (!rst_v) begin
      mem_q.delete();
      last_due       = -1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].addr + 32'h100;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
  endtask

  task automatic endCycle();
    mem_req_t r;
    if (rst_n && prev_hold) begin
      checkOutput("hold_valid", 32'(instr_valid), 32'd1);
      checkOutput("hold_pc", instr_pc, prev_pc);
      checkOutput("hold_instruction", instruction, prev_ins);
    end
    prev_hold = rst_n && !redirect_valid && instr_valid && !instr_ready;
    prev_pc   = instr_pc;
    prev_ins  = instruction;
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (!rst_n) begin
      checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("reset_instr_valid", 32'(instr_valid), 32'd0);
      model_fetch_pc = RESET_PC;
      model_dec_pc   = RESET_PC;
    end else if (redirect_valid) begin
      checkOutput("redirect_req_valid", 32'(imem_req_valid), 32'd0);
      model_fetch_pc = redirect_pc;
      model_dec_pc   = redirect_pc;
    end else begin
      if (imem_req_valid) checkOutput("req_addr", imem_req_addr, model_fetch_pc);
      if (imem_req_valid && imem_req_ready) begin
        r.addr = imem_req_addr;
        r.due  = cycle + int'($urandom_range(lat_max, lat_min));
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        mem_q.push_back(r);
        model_fetch_pc = model_fetch_pc + 32'd4;
      end
      if (instr_valid && instr_ready) begin
        checkOutput("pop_pc", instr_pc, model_dec_pc);
        checkOutput("pop_instruction", instruction, model_dec_pc + 32'h100);
        popped_q.push_back(instr_pc);
        model_dec_pc = model_dec_pc + 32'd4;
        pops++;
      end
    end
    @(posedge clk);
    cycle++;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endCycle();
  endtask

  // Bounded wait for the next head; checks its pc/instruction against the redirect target.
  task automatic expectFirst(input string name, input logic [31:0] target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (instr_valid) begin
        found = 1'b1;
        checkOutput({name, "_pc"}, instr_pc, target);
        checkOutput({name, "_instruction"}, instruction, target + 32'h100);
      end
      endCycle();
    end
    checkOutput({name, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    int fires;
    int pops_before;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0,  32'h0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h100};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h100};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h100};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h100};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h100};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4,  32'h104};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0,  32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  32'h108};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC,  32'h10C};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h0,  32'h0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'h110};

    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rq_rdy, vecs[i].i_rdy, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) checkOutput($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_iv));
      if (vecs[i].exp_iv || !vecs[i].rst) begin
        checkOutput($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d_instruction", i), instruction, vecs[i].exp_ins);
      end
      endCycle();
    end

    // Redirect while two requests are in flight with 3-cycle memory latency.
    lat_min = 3;
    lat_max = 3;
    doReset();
    fires = 0;
    for (int i = 0; i < 10 && fires < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (imem_req_valid && imem_req_ready) fires++;
      endCycle();
    end
    checkOutput("inflight_fires", 32'(fires), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    endCycle();
    expectFirst("inflight_redirect", 32'h40);

    // Redirect coinciding with a response and a pop.
    lat_min = 1;
    lat_max = 1;
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      endCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
    checkOutput("simul_head_valid", 32'(instr_valid), 32'd1);
    checkOutput("simul_rsp_present", 32'(imem_rsp_valid), 32'd1);
    pops_before = pops;
    endCycle();
    checkOutput("simul_no_pop", 32'(pops), 32'(pops_before));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("simul_fifo_empty", 32'(instr_valid), 32'd0);
    endCycle();
    expectFirst("simul_redirect", 32'h80);

    // PC wrap-around through the top of the address space.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    endCycle();
    popped_q.delete();
    for (int i = 0; i < 30 && popped_q.size() < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      endCycle();
    end
    checkOutput("wrap_count", 32'(popped_q.size()), 32'd3);
    if (popped_q.size() >= 3) begin
      checkOutput("wrap_pc0", popped_q[0], 32'hFFFF_FFF8);
      checkOutput("wrap_pc1", popped_q[1], 32'hFFFF_FFFC);
      checkOutput("wrap_pc2", popped_q[2], 32'h0000_0000);
    end

    // Reset with the FIFO full.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      endCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("full_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("full_instr_valid", 32'(instr_valid), 32'd1);
    endCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("midreset_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("midreset_req_valid", 32'(imem_req_valid), 32'd0);
    endCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("postreset_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("postreset_req_addr", imem_req_addr, RESET_PC);
    checkOutput("postreset_instr_valid", 32'(instr_valid), 32'd0);
    endCycle();

    // Random traffic: variable latency, backpressure, redirects and occasional resets.
    lat_min = 1;
    lat_max = 4;
    pops_before = pops;
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_redir;
      logic [31:0] r_pc;
      r_rst   = ($urandom_range(99, 0) != 0);
      r_redir = r_rst && ($urandom_range(19, 0) == 0);
      r_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(r_rst, ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0), r_redir, r_pc);
      endCycle();
    end
    checkOutput("random_progress", 32'(pops - pops_before >= 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
